// File: rtl/alu_result_stage.sv
// Registered result stage behind the 16-bit ALU: 2-entry skid buffer
// plus flags register. Optional parity flag: ALU_RESULT_PARITY_EN.
module alu_result_stage #(
    parameter int W     = 16,
    parameter int DST_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_y,
    input  logic             in_co,
    input  logic             in_m,
    input  logic [DST_W-1:0] in_dst,
    input  logic             in_fwe,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [DST_W-1:0] out_dst,
    output logic [3:0]       flags,
    input  logic             flags_we,
    input  logic [3:0]       flags_wdata,
    output logic [1:0]       occupancy
);

    // entry: {y, dst, p, n, z, c, arith, fwe}
    localparam int EW = W + DST_W + 6;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]    state;
    logic [EW-1:0] head;
    logic [EW-1:0] tail;
    logic [EW-1:0] in_ent;
    logic          acc;
    logic          drn;
    logic          in_p;
    logic          wd_p;
    logic          h_fwe;
    logic          h_arith;
    logic          h_c;
    logic          h_z;
    logic          h_n;
    logic          h_p;
    logic [3:0]    commit_flags;
    logic [3:0]    restore_flags;

`ifdef ALU_RESULT_PARITY_EN
    assign in_p = ~^in_y;
    assign wd_p = flags_wdata[3];
`else
    logic unused_wdata_p;
    assign unused_wdata_p = flags_wdata[3];
    assign in_p = 1'b0;
    assign wd_p = 1'b0;
`endif

    assign in_ent = {in_y, in_dst, in_p, in_y[W-1],
                     (in_y == '0), in_co, ~in_m, in_fwe};

    assign acc = in_valid & in_ready;
    assign drn = out_valid & out_ready;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;

    assign out_data = head[EW-1 -: W];
    assign out_dst  = head[DST_W+5 -: DST_W];
    assign h_p      = head[5];
    assign h_n      = head[4];
    assign h_z      = head[3];
    assign h_c      = head[2];
    assign h_arith  = head[1];
    assign h_fwe    = head[0];

    // logic ops keep the committed carry; arithmetic ops replace it
    assign commit_flags  = {h_p, h_n, h_z, h_arith ? h_c : flags[0]};
    assign restore_flags = {wd_p, flags_wdata[2:0]};

    // skid buffer occupancy FSM; head is always the oldest entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        head  <= in_ent;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        head <= in_ent;
                    end else if (acc) begin
                        tail  <= in_ent;
                        state <= TWO;
                    end else if (drn) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (drn) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // flags commit in order at drain; a direct restore takes priority
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 4'b0000;
        end else if (flags_we) begin
            flags <= restore_flags;
        end else if (drn && h_fwe) begin
            flags <= commit_flags;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: flag vector table, scoreboard on the
// output stream, and hand-written backpressure/restore/reset sequences.
module tb_alu_result_stage;

`ifdef ALU_RESULT_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_y;
    logic        in_co;
    logic        in_m;
    logic [3:0]  in_dst;
    logic        in_fwe;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_dst;
    logic [3:0]  flags;
    logic        flags_we;
    logic [3:0]  flags_wdata;
    logic [1:0]  occupancy;

    alu_result_stage #(.W(16), .DST_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_co(in_co), .in_m(in_m),
        .in_dst(in_dst), .in_fwe(in_fwe),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dst(out_dst),
        .flags(flags), .flags_we(flags_we),
        .flags_wdata(flags_wdata), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] y;
        logic [3:0]  dst;
        logic        co;
        logic        m;
        logic        fwe;
    } ent_t;

    typedef struct {
        logic [15:0] y;
        logic        co;
        logic        m;
        logic        fwe;
        logic [2:0]  nzc;
        logic        p;
    } vec_t;

    ent_t       q[$];
    logic [3:0] mflags;
    int         checks = 0;
    int         errors = 0;
    int         drains = 0;
    logic       last_acc;
    logic       last_drn;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] fmask(input logic [3:0] v);
        return PAR ? v : (v & 4'b0111);
    endfunction

    function automatic logic [3:0] commit(input ent_t e, input logic [3:0] f);
        logic p;
        p = PAR ? ~^e.y : 1'b0;
        return {p, e.y[15], (e.y == 16'h0000), e.m ? f[0] : e.co};
    endfunction

    // one clock: inputs already set at negedge; model the edge, then check
    task automatic step();
        ent_t e;
        #1;
        last_acc = in_valid && in_ready;
        last_drn = out_valid && out_ready;
        if (rst) begin
            q.delete();
            mflags = 4'b0000;
        end else begin
            if (last_drn) begin
                check("drain_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    drains++;
                    check("out_data", out_data, e.y);
                    check("out_dst", out_dst, e.dst);
                    if (flags_we)
                        mflags = fmask(flags_wdata);
                    else if (e.fwe)
                        mflags = commit(e, mflags);
                end
            end else if (flags_we) begin
                mflags = fmask(flags_wdata);
            end
            if (last_acc) begin
                e.y = in_y; e.dst = in_dst; e.co = in_co;
                e.m = in_m; e.fwe = in_fwe;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check("occupancy", occupancy, q.size());
        check("out_valid", out_valid, q.size() != 0);
        check("in_ready", in_ready, q.size() != 2);
        check("flags", flags, mflags);
        @(negedge clk);
    endtask

    task automatic drive(input logic [15:0] y, input logic co,
                         input logic m, input logic fwe,
                         input logic [3:0] dst);
        in_valid = 1'b1;
        in_y = y; in_co = co; in_m = m; in_fwe = fwe; in_dst = dst;
    endtask

    vec_t vt[8];

    initial begin
        int d0;
        int tries;

        vt[0] = '{16'h0000, 1'b1, 1'b0, 1'b1, 3'b011, 1'b1};
        vt[1] = '{16'h1234, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0};
        vt[2] = '{16'h8001, 1'b1, 1'b1, 1'b1, 3'b100, 1'b1};
        vt[3] = '{16'hffff, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1};
        vt[4] = '{16'hffff, 1'b1, 1'b0, 1'b1, 3'b101, 1'b1};
        vt[5] = '{16'h00ff, 1'b0, 1'b1, 1'b1, 3'b001, 1'b1};
        vt[6] = '{16'h0000, 1'b0, 1'b1, 1'b1, 3'b011, 1'b1};
        vt[7] = '{16'h7fff, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_y = '0; in_co = 1'b0;
        in_m = 1'b0; in_dst = '0; in_fwe = 1'b0; out_ready = 1'b0;
        flags_we = 1'b0; flags_wdata = '0; mflags = '0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check("rst_out_data", out_data, 0);
        check("rst_out_dst", out_dst, 0);
        check("rst_flags", flags, 0);
        check("rst_in_ready", in_ready, 1);

        // flag table: accept, then drain next cycle
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].y, vt[i].co, vt[i].m, vt[i].fwe, 4'(i));
            step();
            check("vec_visible", out_valid, 1);
            check("vec_head", out_data, vt[i].y);
            in_valid = 1'b0;
            step();
            check($sformatf("vec%0d_flags", i), flags,
                  {PAR ? vt[i].p : 1'b0, vt[i].nzc});
        end

        // backpressure: two accepted, third waits for a drain
        out_ready = 1'b0;
        drive(16'h0a0a, 1'b0, 1'b1, 1'b0, 4'd1);
        step();
        drive(16'h0b0b, 1'b0, 1'b1, 1'b0, 4'd2);
        step();
        check("bp_occ2", occupancy, 2);
        drive(16'h0c0c, 1'b0, 1'b1, 1'b0, 4'd3);
        step();
        check("bp_third_blocked", last_acc, 0);
        check("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        tries = 0;
        last_acc = 1'b0;
        while (!last_acc && tries < 10) begin
            step();
            tries++;
        end
        check("bp_third_taken", last_acc, 1);
        check("bp_third_after_drain", tries, 2);
        in_valid = 1'b0;
        step();
        check("bp_empty", occupancy, 0);

        // restore wins over a same-cycle commit
        out_ready = 1'b0;
        drive(16'h0000, 1'b1, 1'b0, 1'b1, 4'd5);
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        flags_we = 1'b1;
        flags_wdata = 4'b0101;
        step();
        check("restore_wins", flags, 4'b0101);
        flags_wdata = 4'b1110;
        step();
        check("restore_only", flags, PAR ? 4'b1110 : 4'b0110);
        flags_we = 1'b0;

        // streaming: one result per cycle, in order
        d0 = drains;
        for (int i = 0; i < 8; i++) begin
            drive(16'(i * 16'h1111 + 16'h0101), 1'b1, 1'b0, 1'b1, 4'(15 - i));
            step();
            check("stream_occ", occupancy, 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_count", drains - d0, 8);

        // reset with two entries held
        out_ready = 1'b0;
        drive(16'hffff, 1'b1, 1'b0, 1'b1, 4'd7);
        step();
        drive(16'h8000, 1'b0, 1'b0, 1'b1, 4'd8);
        step();
        check("pre_rst_occ", occupancy, 2);
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        check("rst_occ", occupancy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_flags_clear", flags, 0);
        rst = 1'b0;
        step();
        check("post_rst_flags", flags, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
